// File: rtl/ir_blob_if.sv
// Byte-stream bus between the camera reader and the IR blob decoder.
// The master (camera side) drives the byte stream and reads the decoded outputs.
// The slave (decoder side) receives the byte stream and drives the decoded outputs.
interface ir_blob_if;
  logic        frame_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [10:0] x;
  logic [10:0] y;
  logic [3:0]  size;
  logic        blob_found;
  logic        xy_valid;
  logic        frame_done;
  logic        frame_error;

  modport master (
    output frame_start, byte_in, byte_valid,
    input  x, y, size, blob_found, xy_valid, frame_done, frame_error
  );

  modport slave (
    input  frame_start, byte_in, byte_valid,
    output x, y, size, blob_found, xy_valid, frame_done, frame_error
  );
endinterface

// File: rtl/ir_blob_decoder.sv
// IR sensor extended-mode frame decoder: one header byte, then 4 blobs of
// {X low, Y low, packed}. Blob BLOB_SEL is decoded to x/y/size.
// Optional macro IR_BLOB_FILTER_EN adds a 2-tap IIR ((old+new)>>1) on x/y.
module ir_blob_decoder #(
  parameter int BLOB_SEL    = 0,
  parameter int FRAME_BYTES = 13
) (
  input  logic    clk,
  input  logic    reset,
  ir_blob_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HEADER, BLOB, DONE} state_t;

  localparam int CW = $clog2(FRAME_BYTES + 1);

  state_t      state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]  phase, bidx;
  logic [7:0]  x_lo, y_lo;

  logic        short_frame, acc, blob_wr, last_byte, sel_hit, blob_ok;
  logic [10:0] sx, sy, x_nx, y_nx;

  logic [10:0] x_q, y_q;
  logic [3:0]  size_q;
  logic        found_q, xyv_q, done_q, err_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; frame_start restarts from any state
  always_comb begin
    state_nx = state;
    if (bus.frame_start) state_nx = HEADER;
    else begin
      case (state)
        HEADER:  if (acc) state_nx = BLOB;
        BLOB:    if (last_byte) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  // Per-cycle control decode: which byte is accepted and what it means
  always_comb begin
    short_frame = bus.frame_start && (state == HEADER || state == BLOB);
    acc         = bus.byte_valid && !bus.frame_start && (state != IDLE) &&
                  (cnt < CW'(FRAME_BYTES));
    blob_wr     = acc && (state == BLOB);
    last_byte   = blob_wr && (phase == 2'd2) && (bidx == 2'd3);
    sel_hit     = blob_wr && (phase == 2'd2) && (bidx == 2'(BLOB_SEL));
  end

  // Assemble the candidate sample from held low bytes plus the packed byte
  always_comb begin
    sx      = {1'b0, bus.byte_in[5:4], x_lo};
    sy      = {1'b0, bus.byte_in[7:6], y_lo};
    blob_ok = !((sx == 11'd1023) && (sy == 11'd1023));
  end

`ifdef IR_BLOB_FILTER_EN
  logic [11:0] sum_x, sum_y;
  // Average with the previous output; load raw when there is no valid history
  always_comb begin
    sum_x = {1'b0, x_q} + {1'b0, sx};
    sum_y = {1'b0, y_q} + {1'b0, sy};
    x_nx  = found_q ? 11'(sum_x >> 1) : sx;
    y_nx  = found_q ? 11'(sum_y >> 1) : sy;
  end
`else
  // Raw sample passes straight through
  always_comb begin
    x_nx = sx;
    y_nx = sy;
  end
`endif

  // Byte counter, blob/phase tracking and low-byte holding registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= '0;
      bidx  <= '0;
      x_lo  <= '0;
      y_lo  <= '0;
    end else if (bus.frame_start) begin
      cnt   <= '0;
      phase <= '0;
      bidx  <= '0;
    end else begin
      // acc already excludes a full counter, so this saturates
      if (acc) cnt <= cnt + 1'b1;
      if (blob_wr) begin
        case (phase)
          2'd0:    begin x_lo <= bus.byte_in; phase <= 2'd1; end
          2'd1:    begin y_lo <= bus.byte_in; phase <= 2'd2; end
          default: begin phase <= 2'd0; bidx <= bidx + 2'd1; end
        endcase
      end
    end
  end

  // Decoded outputs and status pulses, one cycle after the triggering byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      size_q  <= '0;
      found_q <= 1'b0;
      xyv_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      xyv_q  <= sel_hit && blob_ok;
      done_q <= acc && (cnt == CW'(FRAME_BYTES - 1));
      err_q  <= short_frame;
      if (sel_hit) begin
        found_q <= blob_ok;
        if (blob_ok) begin
          x_q    <= x_nx;
          y_q    <= y_nx;
          size_q <= bus.byte_in[3:0];
        end
      end
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.size        = size_q;
  assign bus.blob_found  = found_q;
  assign bus.xy_valid    = xyv_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_error = err_q;

endmodule

// File: tb/tb_ir_blob_decoder.sv
// Scoreboard bench for ir_blob_decoder: two instances (BLOB_SEL 0 and 2) see
// the same byte stream; expected updates are queued as bytes are driven and
// popped when xy_valid pulses.
module tb_ir_blob_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;

  always #5 clk = ~clk;

  ir_blob_if b0 ();
  ir_blob_if b2 ();

  assign b0.frame_start = frame_start;
  assign b0.byte_in     = byte_in;
  assign b0.byte_valid  = byte_valid;
  assign b2.frame_start = frame_start;
  assign b2.byte_in     = byte_in;
  assign b2.byte_valid  = byte_valid;

  ir_blob_decoder #(.BLOB_SEL(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  ir_blob_decoder #(.BLOB_SEL(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [10:0] mx [2];
  logic [10:0] my [2];
  logic [3:0]  ms [2];
  logic        mf [2];
  int          sel [2] = '{0, 2};
  logic [25:0] q0 [$];
  logic [25:0] q1 [$];
  int exp_xyv [2] = '{0, 0};
  int n_xyv   [2] = '{0, 0};
  int n_fd    [2] = '{0, 0};
  int n_fe    [2] = '{0, 0};
  int exp_fd = 0;
  int exp_fe = 0;
  logic [7:0] fb [16];
  logic [25:0] e0, e2;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mx[d] = '0; my[d] = '0; ms[d] = '0; mf[d] = 1'b0;
    end
  endtask

  task automatic model_blob(input int d, input logic [7:0] xl, input logic [7:0] yl,
                            input logic [7:0] pk);
    logic [10:0] px, py;
    logic [11:0] s;
    px = {1'b0, pk[5:4], xl};
    py = {1'b0, pk[7:6], yl};
    if (px == 11'd1023 && py == 11'd1023) begin
      mf[d] = 1'b0;
    end else begin
`ifdef IR_BLOB_FILTER_EN
      if (mf[d]) begin
        s = {1'b0, mx[d]} + {1'b0, px}; mx[d] = s[11:1];
        s = {1'b0, my[d]} + {1'b0, py}; my[d] = s[11:1];
      end else begin
        mx[d] = px; my[d] = py;
      end
`else
      s = '0;
      mx[d] = px; my[d] = py;
`endif
      ms[d] = pk[3:0];
      mf[d] = 1'b1;
      exp_xyv[d]++;
      if (d == 0) q0.push_back({mx[d], my[d], ms[d]});
      else        q1.push_back({mx[d], my[d], ms[d]});
    end
  endtask

  // header 00, blob0 and blob2 given as {xlo,ylo,packed}, all else FF
  task automatic fill(input logic [23:0] bl0, input logic [23:0] bl2);
    for (int i = 0; i < 16; i++) fb[i] = 8'hFF;
    fb[0] = 8'h00;
    fb[1] = bl0[23:16]; fb[2] = bl0[15:8]; fb[3] = bl0[7:0];
    fb[7] = bl2[23:16]; fb[8] = bl2[15:8]; fb[9] = bl2[7:0];
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 2; d++)
        if (i == 3 + 3 * sel[d]) model_blob(d, fb[i-2], fb[i-1], fb[i]);
      if (i == 12) exp_fd++;
      send_byte(fb[i]);
      if (i == 12) begin
        chk("fd_at13_0", b0.frame_done, 1'b1);
        chk("fd_at13_2", b2.frame_done, 1'b1);
      end
      if (i == 13) chk("fd_after13", b0.frame_done, 1'b0);
    end
  endtask

  task automatic fstart(input logic exp_err, input logic with_byte);
    frame_start = 1'b1;
    if (with_byte) begin
      byte_valid = 1'b1;
      byte_in    = 8'h77;
    end
    @(negedge clk);
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    if (exp_err) exp_fe++;
    chk("ferr0", b0.frame_error, exp_err);
    chk("ferr2", b2.frame_error, exp_err);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_out0"}, {b0.x, b0.y, b0.size}, {mx[0], my[0], ms[0]});
    chk({tag, "_out2"}, {b2.x, b2.y, b2.size}, {mx[1], my[1], ms[1]});
    chk({tag, "_bf0"}, b0.blob_found, mf[0]);
    chk({tag, "_bf2"}, b2.blob_found, mf[1]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_0"}, {b0.x, b0.y, b0.size, b0.blob_found, b0.xy_valid, b0.frame_done,
                      b0.frame_error}, '0);
    chk({tag, "_2"}, {b2.x, b2.y, b2.size, b2.blob_found, b2.xy_valid, b2.frame_done,
                      b2.frame_error}, '0);
  endtask

  // output monitor: pop expected update on every xy_valid, count pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (b0.xy_valid) begin
        n_xyv[0]++;
        if (q0.size() == 0) chk("xyv0_unexpected", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("upd0", {b0.x, b0.y, b0.size}, e0);
          chk("upd0_bf", b0.blob_found, 1'b1);
        end
      end
      if (b2.xy_valid) begin
        n_xyv[1]++;
        if (q1.size() == 0) chk("xyv2_unexpected", 1, 0);
        else begin
          e2 = q1.pop_front();
          chk("upd2", {b2.x, b2.y, b2.size}, e2);
          chk("upd2_bf", b2.blob_found, 1'b1);
        end
      end
      if (b0.frame_done)  n_fd[0]++;
      if (b2.frame_done)  n_fd[1]++;
      if (b0.frame_error) n_fe[0]++;
      if (b2.frame_error) n_fe[1]++;
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // valid blob0, everything else invalid
    fstart(1'b0, 1'b0);
    fill(24'h34125A, 24'hFFFFFF);
    send_frame(13);
    check_state("f1");
    chk("f1_x", b0.x, 11'h134);
    chk("f1_y", b0.y, 11'h112);
    chk("f1_size", b0.size, 4'hA);

    // all blobs invalid: hold values, blob_found drops
    fstart(1'b0, 1'b0);
    fill(24'hFFFFFF, 24'hFFFFFF);
    send_frame(13);
    check_state("f2");
    chk("f2_hold_x", b0.x, 11'h134);

    // partial selected blob discarded, then short frames
    fstart(1'b0, 1'b0);
    fill(24'h34FFFF, 24'hFFFFFF);
    fb[1] = 8'h34; fb[2] = 8'h12;
    send_frame(3);
    fstart(1'b1, 1'b0);
    fill(24'hFFFFFF, 24'hFFFFFF);
    fb[4] = 8'h00;
    send_frame(5);
    fstart(1'b1, 1'b1);   // same-cycle byte must be dropped
    check_state("short");

    // full frame, 16 bytes: blob0 = 78 56 E3, blob2 = FF 00 30
    fill(24'h7856E3, 24'hFF0030);
    send_frame(16);
    check_state("f3");
    chk("f3_x2", b2.x, 11'd1023);
    chk("f3_y2", b2.y, 11'd0);
    chk("f3_size2", b2.size, 4'h0);
    chk("f3_bf2", b2.blob_found, 1'b1);

    // reset in the middle of a blob
    fstart(1'b0, 1'b0);
    fill(24'h1122FF, 24'hFFFFFF);
    send_frame(3);
    reset = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    check_zero("midrst_hold");
    reset = 1'b0;
    model_reset();
    @(negedge clk);

    // X 100 then 300 on blob0 (reverse on blob2), invalid, then 500
    fstart(1'b0, 1'b0);
    fill(24'h640000, 24'h2C0010);
    send_frame(13);
    check_state("f4");
    chk("f4_x", b0.x, 11'd100);
    fstart(1'b0, 1'b0);
    fill(24'h2C0010, 24'h640000);
    send_frame(13);
    check_state("f5");
`ifdef IR_BLOB_FILTER_EN
    chk("f5_x", b0.x, 11'd200);
`else
    chk("f5_x", b0.x, 11'd300);
`endif
    fstart(1'b0, 1'b0);
    fill(24'hFFFFFF, 24'hFFFFFF);
    send_frame(13);
    check_state("f6");
    fstart(1'b0, 1'b0);
    fill(24'hF40010, 24'hF40010);
    send_frame(13);
    check_state("f7");
    chk("f7_x", b0.x, 11'd500);
    chk("f7_x2", b2.x, 11'd500);

    repeat (3) @(negedge clk);
    chk("xyv_cnt0", n_xyv[0], exp_xyv[0]);
    chk("xyv_cnt2", n_xyv[1], exp_xyv[1]);
    chk("fd_cnt0", n_fd[0], exp_fd);
    chk("fd_cnt2", n_fd[1], exp_fd);
    chk("fe_cnt0", n_fe[0], exp_fe);
    chk("fe_cnt2", n_fe[1], exp_fe);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
